core_axil_bridge: RTL and testbench

- Parametrised successor to the single-core bus glue.
- Generates the core's delayed reset and accepts the core's AXI4-Lite master port.
- Remaps the top address byte through a configurable match table and serialises transactions onto the NMI bus.
- Supports fair read/write arbitration and a bus-timeout that returns SLVERR instead of hanging the core.

---
 rtl/core_axil_bridge.sv | 179 +++++++++++++++++
 tb/tb_core_axil_bridge.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_axil_bridge.sv
// AXI4-Lite slave to NMI master bridge with delayed core reset, top-byte remap,
// alternating read/write arbitration and an NMI timeout that answers SLVERR.
module core_axil_bridge #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NUM_REMAP = 2,
    parameter int RST_DLY_W = 19,
    parameter int TMO_W     = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   core_rst_o,
    input  logic [NUM_REMAP*8-1:0] remap_match_i,
    input  logic [NUM_REMAP*8-1:0] remap_base_i,
    input  logic [NUM_REMAP-1:0]   remap_en_i,
    input  logic [TMO_W-1:0]       tmo_lim_i,
    input  logic [ADDR_W-1:0]      awaddr_i,
    input  logic                   awvalid_i,
    output logic                   awready_o,
    input  logic [DATA_W-1:0]      wdata_i,
    input  logic [DATA_W/8-1:0]    wstrb_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    output logic [1:0]             bresp_o,
    output logic                   bvalid_o,
    input  logic                   bready_i,
    input  logic [ADDR_W-1:0]      araddr_i,
    input  logic                   arvalid_i,
    output logic                   arready_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic [1:0]             rresp_o,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic                   mem_valid_o,
    output logic [ADDR_W-1:0]      mem_addr_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    output logic [DATA_W/8-1:0]    mem_wstrb_o,
    input  logic [DATA_W-1:0]      mem_rdata_i,
    input  logic                   mem_ready_i,
    output logic                   tmo_flag_o
);

    typedef enum logic [1:0] {IDLE, NMI, BRESP, RRESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t               state, state_nxt;
    logic [RST_DLY_W-1:0] dly_cnt;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 last_wr;
    logic                 is_wr;
    logic [1:0]           resp_q;
    logic                 grant_wr;
    logic                 grant_rd;
    logic                 tmo_hit;

    // Lowest-index enabled entry whose match byte equals the top address byte wins.
    function automatic logic [ADDR_W-1:0] remap_addr(
        input logic [ADDR_W-1:0]      addr,
        input logic [NUM_REMAP*8-1:0] match,
        input logic [NUM_REMAP*8-1:0] base,
        input logic [NUM_REMAP-1:0]   en
    );
        logic [ADDR_W-1:0] res;
        logic              hit;
        res = addr;
        hit = 1'b0;
        for (int i = 0; i < NUM_REMAP; i++) begin
            if (!hit && en[i] && (match[i*8 +: 8] == addr[ADDR_W-1 -: 8])) begin
                res[ADDR_W-1 -: 8] = base[i*8 +: 8];
                hit                = 1'b1;
            end
        end
        return res;
    endfunction

    assign core_rst_o  = (dly_cnt != '1);
    assign tmo_hit     = (tmo_lim_i != '0) && (tmo_cnt == tmo_lim_i - TMO_W'(1));
    assign mem_valid_o = (state == NMI);
    assign bvalid_o    = (state == BRESP);
    assign rvalid_o    = (state == RRESP);
    assign bresp_o     = resp_q;
    assign rresp_o     = resp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dly_cnt <= '0;
            state   <= IDLE;
        end else begin
            if (dly_cnt != '1) begin
                dly_cnt <= dly_cnt + RST_DLY_W'(1);
            end
            state <= state_nxt;
        end
    end

    // A write needs AW and W together; with both sides pending, the side not served last goes.
    always_comb begin
        state_nxt = state;
        grant_wr  = 1'b0;
        grant_rd  = 1'b0;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        arready_o = 1'b0;
        case (state)
            IDLE: begin
                if (!core_rst_o) begin
                    grant_wr  = awvalid_i && wvalid_i && (!arvalid_i || !last_wr);
                    grant_rd  = arvalid_i && !grant_wr;
                    awready_o = grant_wr;
                    wready_o  = grant_wr;
                    arready_o = grant_rd;
                    if (grant_wr || grant_rd) begin
                        state_nxt = NMI;
                    end
                end
            end
            NMI: begin
                if (mem_ready_i || tmo_hit) begin
                    state_nxt = is_wr ? BRESP : RRESP;
                end
            end
            BRESP: begin
                if (bready_i) begin
                    state_nxt = IDLE;
                end
            end
            RRESP: begin
                if (rready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_wstrb_o <= '0;
            rdata_o     <= '0;
            resp_q      <= RESP_OKAY;
            tmo_cnt     <= '0;
            tmo_flag_o  <= 1'b0;
            last_wr     <= 1'b0;
            is_wr       <= 1'b0;
        end else begin
            tmo_flag_o <= 1'b0;
            if (grant_wr || grant_rd) begin
                mem_addr_o  <= remap_addr(grant_wr ? awaddr_i : araddr_i,
                                          remap_match_i, remap_base_i, remap_en_i);
                mem_wdata_o <= wdata_i;
                mem_wstrb_o <= grant_wr ? wstrb_i : '0;
                is_wr       <= grant_wr;
                last_wr     <= grant_wr;
                tmo_cnt     <= '0;
            end
            // A ready in the same cycle as the timeout still completes with OKAY.
            if (state == NMI) begin
                if (mem_ready_i) begin
                    resp_q <= RESP_OKAY;
                    if (!is_wr) begin
                        rdata_o <= mem_rdata_i;
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (tmo_hit) begin
                        resp_q     <= RESP_SLVERR;
                        rdata_o    <= '0;
                        tmo_flag_o <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_core_axil_bridge.sv
// Bench for core_axil_bridge: transaction-level model checked every cycle,
// plus directed reset-delay, remap, write, arbitration, timeout and abort scenarios.
module tb_core_axil_bridge;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int NUM_REMAP = 2;
    localparam int RST_DLY_W = 4;
    localparam int TMO_W     = 8;
    localparam int DLY_MAX   = (1 << RST_DLY_W) - 1;

    localparam int S_AR = 0, S_AW = 1, S_MV = 2, S_RV = 3, S_BV = 4, S_TF = 5;

    logic                   clk = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   core_rst_o;
    logic [NUM_REMAP*8-1:0] remap_match_i = '0;
    logic [NUM_REMAP*8-1:0] remap_base_i = '0;
    logic [NUM_REMAP-1:0]   remap_en_i = '0;
    logic [TMO_W-1:0]       tmo_lim_i = '0;
    logic [ADDR_W-1:0]      awaddr_i = '0;
    logic                   awvalid_i = 1'b0;
    logic                   awready_o;
    logic [DATA_W-1:0]      wdata_i = '0;
    logic [DATA_W/8-1:0]    wstrb_i = '0;
    logic                   wvalid_i = 1'b0;
    logic                   wready_o;
    logic [1:0]             bresp_o;
    logic                   bvalid_o;
    logic                   bready_i = 1'b0;
    logic [ADDR_W-1:0]      araddr_i = '0;
    logic                   arvalid_i = 1'b0;
    logic                   arready_o;
    logic [DATA_W-1:0]      rdata_o;
    logic [1:0]             rresp_o;
    logic                   rvalid_o;
    logic                   rready_i = 1'b0;
    logic                   mem_valid_o;
    logic [ADDR_W-1:0]      mem_addr_o;
    logic [DATA_W-1:0]      mem_wdata_o;
    logic [DATA_W/8-1:0]    mem_wstrb_o;
    logic [DATA_W-1:0]      mem_rdata_i = '0;
    logic                   mem_ready_i = 1'b0;
    logic                   tmo_flag_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rsp_lat = 0;
    int rsp_cnt = 0;
    bit chk_en = 1'b0;

    core_axil_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REMAP(NUM_REMAP),
        .RST_DLY_W(RST_DLY_W), .TMO_W(TMO_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .core_rst_o(core_rst_o),
        .remap_match_i(remap_match_i), .remap_base_i(remap_base_i), .remap_en_i(remap_en_i),
        .tmo_lim_i(tmo_lim_i),
        .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
        .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .tmo_flag_o(tmo_flag_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    int                m_age = 0;      // cycles since reset release, saturating
    int                m_phase = 0;    // 0 waiting for request, 1 on NMI bus, 2 answering
    bit                m_wr = 0;
    bit                m_last = 0;     // last granted transaction was a write
    int                m_waited = 0;
    bit                m_flag = 0;
    logic [1:0]        m_resp = 0;
    logic [DATA_W-1:0] m_rdata = 0;
    logic [ADDR_W-1:0] m_addr = 0;
    logic [DATA_W-1:0] m_wdata = 0;
    logic [3:0]        m_wstrb = 0;

    function automatic logic [ADDR_W-1:0] model_remap(input logic [ADDR_W-1:0] a);
        logic [7:0] top;
        logic [7:0] rep;
        top = a[31:24];
        rep = top;
        for (int i = NUM_REMAP - 1; i >= 0; i--)
            if (remap_en_i[i] && remap_match_i[i*8 +: 8] == top) rep = remap_base_i[i*8 +: 8];
        return {rep, a[23:0]};
    endfunction

    function automatic bit exp_core_rst();
        return m_age < DLY_MAX;
    endfunction

    function automatic bit exp_gw();
        return m_phase == 0 && !exp_core_rst() && awvalid_i && wvalid_i && (!arvalid_i || !m_last);
    endfunction

    function automatic bit exp_gr();
        return m_phase == 0 && !exp_core_rst() && arvalid_i && !exp_gw();
    endfunction

    always @(posedge clk) begin
        bit gw, gr;
        if (rst_i) begin
            m_age = 0; m_phase = 0; m_last = 0; m_flag = 0; m_wr = 0;
            m_resp = 0; m_rdata = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0;
        end else begin
            gw = exp_gw();
            gr = exp_gr();
            m_flag = 0;
            if (m_phase == 0) begin
                if (gw || gr) begin
                    m_wr = gw; m_last = gw;
                    m_addr = model_remap(gw ? awaddr_i : araddr_i);
                    m_wdata = wdata_i;
                    m_wstrb = gw ? wstrb_i : 4'h0;
                    m_waited = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (mem_ready_i) begin
                    m_resp = 2'b00;
                    if (!m_wr) m_rdata = mem_rdata_i;
                    m_phase = 2;
                end else begin
                    m_waited++;
                    if (tmo_lim_i != 0 && m_waited == int'(tmo_lim_i)) begin
                        m_resp = 2'b10; m_rdata = 0; m_flag = 1; m_phase = 2;
                    end
                end
            end else if (m_wr ? bready_i : rready_i) begin
                m_phase = 0;
            end
            if (m_age < DLY_MAX) m_age++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("core_rst", core_rst_o, exp_core_rst());
            check("awready", awready_o, exp_gw());
            check("wready", wready_o, exp_gw());
            check("arready", arready_o, exp_gr());
            check("mem_valid", mem_valid_o, m_phase == 1);
            if (m_phase == 1) begin
                check("mem_addr", mem_addr_o, m_addr);
                check("mem_wstrb", mem_wstrb_o, m_wstrb);
                if (m_wr) check("mem_wdata", mem_wdata_o, m_wdata);
            end
            check("bvalid", bvalid_o, m_phase == 2 && m_wr);
            check("rvalid", rvalid_o, m_phase == 2 && !m_wr);
            if (m_phase == 2 && m_wr) check("bresp", bresp_o, m_resp);
            if (m_phase == 2 && !m_wr) begin
                check("rresp", rresp_o, m_resp);
                check("rdata", rdata_o, m_rdata);
            end
            check("tmo_flag", tmo_flag_o, m_flag);
        end
    end

    // NMI slave: answers after rsp_lat wait cycles, never when rsp_lat < 0.
    always @(posedge clk) begin
        #1;
        if (rst_i || mem_ready_i) begin
            mem_ready_i = 1'b0;
            rsp_cnt = 0;
        end else if (!mem_valid_o) begin
            rsp_cnt = 0;
        end else if (rsp_lat >= 0) begin
            rsp_cnt++;
            if (rsp_cnt > rsp_lat) mem_ready_i = 1'b1;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input int sel, input int limit, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            case (sel)
                S_AR:    hit = arready_o;
                S_AW:    hit = awready_o;
                S_MV:    hit = mem_valid_o;
                S_RV:    hit = rvalid_o;
                S_BV:    hit = bvalid_o;
                default: hit = tmo_flag_o;
            endcase
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL %s: not seen within %0d cycles", nm, limit);
        end
    endtask

    task automatic start_read(input logic [31:0] addr, input int lat, input logic [31:0] mdata,
                              input int wlim);
        rsp_lat = lat;
        mem_rdata_i = mdata;
        araddr_i = addr;
        arvalid_i = 1'b1;
        wait_sig(S_AR, wlim, "arready");
    endtask

    task automatic finish_read(input logic [31:0] exp_addr, input logic [1:0] exp_resp,
                               input logic [31:0] exp_rdata);
        tick();
        arvalid_i = 1'b0;
        wait_sig(S_MV, 4, "mem_valid");
        check("rd_mem_addr", mem_addr_o, exp_addr);
        check("rd_mem_wstrb", mem_wstrb_o, 4'h0);
        wait_sig(S_RV, 30, "rvalid");
        check("rd_rresp", rresp_o, exp_resp);
        check("rd_rdata", rdata_o, exp_rdata);
        tick();
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
    endtask

    initial begin
        int n_rst;
        int c0;
        int grants[$];
        remap_match_i = {8'ha0, 8'h30};
        remap_base_i  = {8'h40, 8'h00};
        remap_en_i    = 2'b11;
        tmo_lim_i     = 8'd5;
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_core_rst", core_rst_o, 1'b1);
        check("rst_mem_valid", mem_valid_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wstrb", mem_wstrb_o, 4'h0);
        check("rst_bvalid", bvalid_o, 1'b0);
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_bresp", bresp_o, 2'b00);
        check("rst_tmo_flag", tmo_flag_o, 1'b0);

        // Reset delay with a read already pending; it is granted once the core leaves reset.
        tick();
        rst_i = 1'b0;
        rsp_lat = 1;
        mem_rdata_i = 32'h1111_2222;
        araddr_i = 32'h3000_1234;
        arvalid_i = 1'b1;
        n_rst = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (core_rst_o !== 1'b1) break;
            if (arready_o !== 1'b0) check("dly_arready", arready_o, 1'b0);
            n_rst++;
        end
        check("dly_cycles", n_rst, 15);
        check("dly_first_grant", arready_o, 1'b1);
        finish_read(32'h0000_1234, 2'b00, 32'h1111_2222);

        start_read(32'ha000_0010, 0, 32'h5555_aaaa, 10);
        finish_read(32'h4000_0010, 2'b00, 32'h5555_aaaa);
        start_read(32'h1000_0000, 2, 32'h0bad_f00d, 10);
        finish_read(32'h1000_0000, 2'b00, 32'h0bad_f00d);
        remap_en_i = 2'b10;
        start_read(32'h3000_5678, 0, 32'h1234_5678, 10);
        finish_read(32'h3000_5678, 2'b00, 32'h1234_5678);
        remap_en_i = 2'b11;

        // Write with a slow slave and a stalled B channel.
        rsp_lat = 3;
        awaddr_i = 32'h0300_0000;
        wdata_i = 32'hDEAD_BEEF;
        wstrb_i = 4'hF;
        awvalid_i = 1'b1;
        wvalid_i = 1'b1;
        wait_sig(S_AW, 10, "awready");
        check("wr_wready", wready_o, 1'b1);
        tick();
        awvalid_i = 1'b0;
        wvalid_i = 1'b0;
        wait_sig(S_MV, 4, "wr_mem_valid");
        check("wr_mem_addr", mem_addr_o, 32'h0300_0000);
        check("wr_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        check("wr_mem_wstrb", mem_wstrb_o, 4'hF);
        wait_sig(S_BV, 10, "bvalid");
        check("wr_bresp", bresp_o, 2'b00);
        @(negedge clk);
        check("wr_bvalid_hold1", bvalid_o, 1'b1);
        @(negedge clk);
        check("wr_bvalid_hold2", bvalid_o, 1'b1);
        tick();
        bready_i = 1'b1;
        tick();
        bready_i = 1'b0;

        // Timeout: limit 5, slave never answers.
        tmo_lim_i = 8'd5;
        start_read(32'ha000_0020, -1, 32'hffff_ffff, 10);
        tick();
        arvalid_i = 1'b0;
        wait_sig(S_MV, 4, "tmo_mem_valid");
        c0 = cyc;
        wait_sig(S_TF, 20, "tmo_flag");
        check("tmo_delay", cyc - c0, 5);
        check("tmo_rvalid", rvalid_o, 1'b1);
        check("tmo_rresp", rresp_o, 2'b10);
        check("tmo_rdata", rdata_o, 32'h0);
        tick();
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;

        // Timeout disabled: the bus stays busy, then a reset aborts it.
        tmo_lim_i = 8'd0;
        start_read(32'h3000_0000, -1, 32'h0, 10);
        tick();
        arvalid_i = 1'b0;
        wait_sig(S_MV, 4, "notmo_mem_valid");
        repeat (1000) @(negedge clk);
        check("notmo_rvalid", rvalid_o, 1'b0);
        check("notmo_mem_valid", mem_valid_o, 1'b1);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        check("abort_mem_valid", mem_valid_o, 1'b0);
        check("abort_core_rst", core_rst_o, 1'b1);
        tick();
        tmo_lim_i = 8'd5;
        start_read(32'h1000_0040, 2, 32'hcafe_0001, 40);
        finish_read(32'h1000_0040, 2'b00, 32'hcafe_0001);

        // Arbitration: both sides pending continuously from reset release.
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        rsp_lat = 0;
        bready_i = 1'b1;
        rready_i = 1'b1;
        awaddr_i = 32'ha000_0004;
        wdata_i = 32'h0102_0304;
        wstrb_i = 4'h3;
        araddr_i = 32'h3000_0008;
        mem_rdata_i = 32'h7777_0000;
        awvalid_i = 1'b1;
        wvalid_i = 1'b1;
        arvalid_i = 1'b1;
        for (int i = 0; i < 200 && grants.size() < 4; i++) begin
            @(negedge clk);
            if (awready_o) grants.push_back(1);
            else if (arready_o) grants.push_back(0);
        end
        tick();
        awvalid_i = 1'b0;
        wvalid_i = 1'b0;
        arvalid_i = 1'b0;
        check("arb_count", grants.size(), 4);
        while (grants.size() < 4) grants.push_back(-1);
        check("arb_g0_write", grants[0], 1);
        check("arb_g1_read", grants[1], 0);
        check("arb_g2_write", grants[2], 1);
        check("arb_g3_read", grants[3], 0);
        repeat (10) tick();
        bready_i = 1'b0;
        rready_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
